// File: rtl/intersection_scheduler_pkg.sv
// Shared types and timing defaults for the intersection scheduler.
// Optional feature macro: EMERGENCY_PREEMPT_EN (adds preempt ports on the interface).
package intersection_scheduler_pkg;

  localparam logic [2:0] LIGHT_G = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_R = 3'b001;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2
  } phase_e;

  localparam int DEF_N_APPROACH = 4;
  localparam int DEF_MIN_GREEN  = 4;
  localparam int DEF_MAX_GREEN  = 12;
  localparam int DEF_YELLOW_T   = 2;
  localparam int DEF_ALLRED_T   = 1;
  localparam int DEF_TIMER_W    = 4;

endpackage

// File: rtl/intersection_scheduler_if.sv
// Road-side bundle: car sensors in, light/grant/phase outputs out.
// Optional feature macro: EMERGENCY_PREEMPT_EN (adds preempt and preempt_id).
interface intersection_scheduler_if #(
  parameter int N_APPROACH = 4
);
  logic [N_APPROACH-1:0]       has_car;
  logic [N_APPROACH-1:0][2:0]  lights;
  logic [N_APPROACH-1:0]       grant;
  logic                        phase_start;
`ifdef EMERGENCY_PREEMPT_EN
  logic                          preempt;
  logic [$clog2(N_APPROACH)-1:0] preempt_id;

  modport master (output has_car, output preempt, output preempt_id,
                  input lights, input grant, input phase_start);
  modport slave  (input has_car, input preempt, input preempt_id,
                  output lights, output grant, output phase_start);
`else
  modport master (output has_car, input lights, input grant, input phase_start);
  modport slave  (input has_car, output lights, output grant, output phase_start);
`endif
endinterface

// File: rtl/intersection_scheduler_rr_picker.sv
// Round-robin pick: first requesting index after cur, wrapping so cur itself is checked last.
// Optional feature macro EMERGENCY_PREEMPT_EN is not used here.
module intersection_scheduler_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] cur_i,
  output logic [IDX_W-1:0] nxt_o,
  output logic             vld_o
);

  always_comb begin
    int j;
    logic [IDX_W-1:0] jj;
    j     = 0;
    jj    = '0;
    nxt_o = '0;
    vld_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = int'(cur_i) + k;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!vld_o && req_i[jj]) begin
        vld_o = 1'b1;
        nxt_o = jj;
      end
    end
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Multi-approach intersection phase sequencer: GREEN -> YELLOW -> ALLRED, round-robin over latched requests.
// Optional feature macro: EMERGENCY_PREEMPT_EN (preempt/preempt_id force the next green).
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int N_APPROACH = DEF_N_APPROACH,
  parameter int MIN_GREEN  = DEF_MIN_GREEN,
  parameter int MAX_GREEN  = DEF_MAX_GREEN,
  parameter int YELLOW_T   = DEF_YELLOW_T,
  parameter int ALLRED_T   = DEF_ALLRED_T,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input  logic                     CLK,
  input  logic                     RESET,
  intersection_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(N_APPROACH);
  localparam logic [TIMER_W-1:0] MING_M1 = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAXG_M1 = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_M1  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] AR_M1   = TIMER_W'(ALLRED_T - 1);

  phase_e                          state_q, state_d;
  logic [IDX_W-1:0]                cur_q, cur_d;
  logic [TIMER_W-1:0]              timer_q, timer_d;
  logic [N_APPROACH-1:0]           pending_q, pending_d;
  logic                            enter_q, enter_d;
  logic [N_APPROACH-1:0][2:0]      lights_q, lights_d, lights_rst;
  logic [N_APPROACH-1:0]           grant_q, grant_d;
  logic                            pstart_q;

  logic [N_APPROACH-1:0] cur_oh;
  logic                  other;
  logic [IDX_W-1:0]      pick_idx, nxt;
  logic                  pick_vld;

  always_comb begin
    cur_oh        = '0;
    cur_oh[cur_q] = 1'b1;
  end

  assign other = |(pending_q & ~cur_oh);

  intersection_scheduler_rr_picker #(.N(N_APPROACH), .IDX_W(IDX_W)) u_pick (
    .req_i (pending_q),
    .cur_i (cur_q),
    .nxt_o (pick_idx),
    .vld_o (pick_vld)
  );

`ifdef EMERGENCY_PREEMPT_EN
  assign nxt = bus.preempt ? bus.preempt_id : (pick_vld ? pick_idx : '0);
`else
  assign nxt = pick_vld ? pick_idx : '0;
`endif

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    timer_d   = timer_q;
    enter_d   = 1'b0;
    // the current green owner never latches its own car; everyone else does
    pending_d = pending_q | (bus.has_car & ~((state_q == PH_GREEN) ? cur_oh : '0));
    case (state_q)
      PH_GREEN: begin
        if (timer_q != MAXG_M1) timer_d = timer_q + 1'b1;
`ifdef EMERGENCY_PREEMPT_EN
        if (bus.preempt) begin
          if (bus.preempt_id == cur_q) begin
            timer_d = timer_q;
          end else begin
            state_d = PH_YELLOW;
            timer_d = '0;
          end
        end else
`endif
        if (other && timer_q >= MING_M1 && (!bus.has_car[cur_q] || timer_q == MAXG_M1)) begin
          state_d = PH_YELLOW;
          timer_d = '0;
        end
      end
      PH_YELLOW: begin
        if (timer_q == YEL_M1) begin
          state_d = PH_ALLRED;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PH_ALLRED: begin
        if (timer_q == AR_M1) begin
          state_d        = PH_GREEN;
          timer_d        = '0;
          cur_d          = nxt;
          pending_d[nxt] = 1'b0;
          enter_d        = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d   = PH_GREEN;
        cur_d     = '0;
        timer_d   = '0;
        pending_d = '0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_APPROACH; i++) lights_rst[i] = LIGHT_R;
    lights_rst[0] = LIGHT_G;
  end

  // outputs follow the registered state, so they trail a state change by one cycle
  always_comb begin
    for (int i = 0; i < N_APPROACH; i++) lights_d[i] = LIGHT_R;
    grant_d = cur_oh;
    case (state_q)
      PH_GREEN:  lights_d[cur_q] = LIGHT_G;
      PH_YELLOW: lights_d[cur_q] = LIGHT_Y;
      PH_ALLRED: ;
      default: begin
        lights_d = lights_rst;
        grant_d  = N_APPROACH'(1);
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= PH_GREEN;
      cur_q     <= '0;
      timer_q   <= '0;
      pending_q <= '0;
      enter_q   <= 1'b0;
      lights_q  <= lights_rst;
      grant_q   <= N_APPROACH'(1);
      pstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      enter_q   <= enter_d;
      lights_q  <= lights_d;
      grant_q   <= grant_d;
      pstart_q  <= enter_q;
    end
  end

  assign bus.lights      = lights_q;
  assign bus.grant       = grant_q;
  assign bus.phase_start = pstart_q;

endmodule
